// File: rtl/br_predict_resolve.sv
// Branch prediction and resolution unit: BHT of saturating counters read by IF,
// condition evaluation, redirect generation and training in EX, plus perf counters.
module br_predict_resolve #(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CTR_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_IF,
  output logic             pred_taken_IF,
  input  logic [PC_W-1:0]  pc_ID_EX,
  input  logic             pred_taken_ID_EX,
  input  logic             br_instr_ID_EX,
  input  logic             jmp_imm_ID_EX,
  input  logic             jmp_reg_ID_EX,
  input  logic [2:0]       cc_ID_EX,
  input  logic             clk_z_ID_EX,
  input  logic             clk_nv_ID_EX,
  input  logic             zr,
  input  logic             neg,
  input  logic             ov,
  input  logic             stall_ID_EX,
  input  logic             clr_stats,
  output logic             flow_change_ID_EX,
  output logic             actual_taken_ID_EX,
  output logic             zr_EX_DM,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } cc_e;

  logic [CTR_W-1:0] bht [BHT_DEPTH];
  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic             neg_f;
  logic             ov_f;
  logic             cond;
  logic             is_jump;
  logic             train;
  logic             mispred;
  logic             unused_pc;

  assign idx_if = pc_IF[IDX_W-1:0];
  assign idx_ex = pc_ID_EX[IDX_W-1:0];

  // Only the low PC bits index the table; the rest are intentionally ignored.
  assign unused_pc = ^{pc_IF[PC_W-1:IDX_W], pc_ID_EX[PC_W-1:IDX_W]};

  // Flags seen by EX are those of the previous flag-setting instruction.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr_EX_DM <= 1'b0;
      neg_f    <= 1'b0;
      ov_f     <= 1'b0;
    end else if (!stall_ID_EX) begin
      if (clk_z_ID_EX) zr_EX_DM <= zr;
      if (clk_nv_ID_EX) begin
        neg_f <= neg;
        ov_f  <= ov;
      end
    end
  end

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    cond = 1'b0;
    case (cc_e'(cc_ID_EX))
      CC_NE:   cond = ~zr_EX_DM;
      CC_EQ:   cond = zr_EX_DM;
      CC_GT:   cond = ~zr_EX_DM & ~neg_f;
      CC_LT:   cond = neg_f;
      CC_GE:   cond = zr_EX_DM | ~neg_f;
      CC_LE:   cond = neg_f | zr_EX_DM;
      CC_OV:   cond = ov_f;
      CC_UN:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign is_jump            = jmp_imm_ID_EX | jmp_reg_ID_EX;
  assign mispred            = cond ^ pred_taken_ID_EX;
  assign actual_taken_ID_EX = is_jump | (br_instr_ID_EX & cond);
  assign flow_change_ID_EX  = is_jump | (br_instr_ID_EX & mispred);

  // A jump colliding with a branch flag wins and suppresses training.
  assign train = br_instr_ID_EX & ~is_jump & ~stall_ID_EX;

  // IF reads the pre-update value on a same-index collision.
  assign pred_taken_IF = bht[idx_if][CTR_W-1];

  // NOTE: the table must come out of reset weakly not-taken, so every entry is reset
  // explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (train) begin
      if (cond) begin
        if (bht[idx_ex] != CTR_MAX) bht[idx_ex] <= bht[idx_ex] + CTR_W'(1);
      end else begin
        if (bht[idx_ex] != '0) bht[idx_ex] <= bht[idx_ex] - CTR_W'(1);
      end
    end
  end

  // Perf counters: clear dominates, increments saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (clr_stats) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (train) begin
      if (br_count != CNT_MAX) br_count <= br_count + CNT_W'(1);
      if (mispred && (mispred_count != CNT_MAX)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_predict_resolve.sv
// Directed bench for br_predict_resolve: stimulus pushes hand-computed expectations,
// a monitor pops and compares them against the DUT outputs.
module tb_br_predict_resolve;

  localparam int PC_W  = 16;
  localparam int CNT_W = 16;

  typedef enum {S_PRED, S_FC, S_AT, S_ZR, S_BRC, S_MPC} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [PC_W-1:0]  pc_IF;
  logic             pred_taken_IF;
  logic [PC_W-1:0]  pc_ID_EX;
  logic             pred_taken_ID_EX;
  logic             br_instr_ID_EX;
  logic             jmp_imm_ID_EX;
  logic             jmp_reg_ID_EX;
  logic [2:0]       cc_ID_EX;
  logic             clk_z_ID_EX;
  logic             clk_nv_ID_EX;
  logic             zr;
  logic             neg;
  logic             ov;
  logic             stall_ID_EX;
  logic             clr_stats;
  logic             flow_change_ID_EX;
  logic             actual_taken_ID_EX;
  logic             zr_EX_DM;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  exp_t sb[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  br_predict_resolve #(.PC_W(PC_W), .BHT_DEPTH(16), .CTR_W(2), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_IF             (pc_IF),
    .pred_taken_IF     (pred_taken_IF),
    .pc_ID_EX          (pc_ID_EX),
    .pred_taken_ID_EX  (pred_taken_ID_EX),
    .br_instr_ID_EX    (br_instr_ID_EX),
    .jmp_imm_ID_EX     (jmp_imm_ID_EX),
    .jmp_reg_ID_EX     (jmp_reg_ID_EX),
    .cc_ID_EX          (cc_ID_EX),
    .clk_z_ID_EX       (clk_z_ID_EX),
    .clk_nv_ID_EX      (clk_nv_ID_EX),
    .zr                (zr),
    .neg               (neg),
    .ov                (ov),
    .stall_ID_EX       (stall_ID_EX),
    .clr_stats         (clr_stats),
    .flow_change_ID_EX (flow_change_ID_EX),
    .actual_taken_ID_EX(actual_taken_ID_EX),
    .zr_EX_DM          (zr_EX_DM),
    .br_count          (br_count),
    .mispred_count     (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual_of(sig_e s);
    case (s)
      S_PRED:  return {15'd0, pred_taken_IF};
      S_FC:    return {15'd0, flow_change_ID_EX};
      S_AT:    return {15'd0, actual_taken_ID_EX};
      S_ZR:    return {15'd0, zr_EX_DM};
      S_BRC:   return br_count;
      S_MPC:   return mispred_count;
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: on each sample request, wait off the edge and drain the scoreboard.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [15:0] act;
        e   = sb.pop_front();
        act = actual_of(e.sig);
        n_tests++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input sig_e sig, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic flush();
    -> sample_ev;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ex_idle();
    br_instr_ID_EX   = 1'b0;
    jmp_imm_ID_EX    = 1'b0;
    jmp_reg_ID_EX    = 1'b0;
    pred_taken_ID_EX = 1'b0;
    clk_z_ID_EX      = 1'b0;
    clk_nv_ID_EX     = 1'b0;
    stall_ID_EX      = 1'b0;
    clr_stats        = 1'b0;
  endtask

  task automatic branch(input logic [15:0] pc, input logic [2:0] cc, input logic pred);
    pc_ID_EX         = pc;
    cc_ID_EX         = cc;
    pred_taken_ID_EX = pred;
    br_instr_ID_EX   = 1'b1;
  endtask

  task automatic load_flags(input logic z, input logic n, input logic v);
    ex_idle();
    zr = z; neg = n; ov = v;
    clk_z_ID_EX  = 1'b1;
    clk_nv_ID_EX = 1'b1;
    step();
    clk_z_ID_EX  = 1'b0;
    clk_nv_ID_EX = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [15:0] brc, input logic [15:0] mpc);
    check({tag, "_brc"}, S_BRC, brc);
    check({tag, "_mpc"}, S_MPC, mpc);
    flush();
  endtask

  // Expected cond per cc for flag set A (z0 n1 v0) and set B (z1 n0 v1).
  logic [7:0] cond_a = 8'b1010_1001;
  logic [7:0] cond_b = 8'b1111_0010;

  initial begin
    rst_n = 1'b0;
    pc_IF = '0;
    pc_ID_EX = '0;
    cc_ID_EX = '0;
    zr = 1'b0; neg = 1'b0; ov = 1'b0;
    ex_idle();
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      pc_IF = 16'(i);
      check($sformatf("rst_pred_%0d", i), S_PRED, 16'd0);
      flush();
    end
    check("rst_zr", S_ZR, 16'd0);
    check_stats("rst", 16'd0, 16'd0);

    // Condition codes, stalled so nothing trains
    load_flags(1'b0, 1'b1, 1'b0);
    check("flagsA_zr", S_ZR, 16'd0);
    flush();
    for (int c = 0; c < 8; c++) begin
      branch(16'h0001, 3'(c), 1'b0);
      stall_ID_EX = 1'b1;
      check($sformatf("ccA_at_%0d", c), S_AT, {15'd0, cond_a[c]});
      check($sformatf("ccA_fc_%0d", c), S_FC, {15'd0, cond_a[c]});
      flush();
    end
    load_flags(1'b1, 1'b0, 1'b1);
    check("flagsB_zr", S_ZR, 16'd1);
    flush();
    for (int c = 0; c < 8; c++) begin
      branch(16'h0001, 3'(c), 1'b0);
      stall_ID_EX = 1'b1;
      check($sformatf("ccB_at_%0d", c), S_AT, {15'd0, cond_b[c]});
      check($sformatf("ccB_fc_%0d", c), S_FC, {15'd0, cond_b[c]});
      flush();
    end
    step();
    check_stats("cc_stalled", 16'd0, 16'd0);
    // Flag load blocked by stall
    ex_idle();
    stall_ID_EX = 1'b1; clk_z_ID_EX = 1'b1; zr = 1'b0;
    step();
    check("zr_held_by_stall", S_ZR, 16'd1);
    flush();

    // Saturation on index 5, observed through pc 0x0015 (flags z1 n0 v1)
    ex_idle();
    pc_IF = 16'h0015;
    branch(16'h0005, 3'b111, 1'b0);
    check("sat_pred_01", S_PRED, 16'd0);
    check("sat_fc_mispred", S_FC, 16'd1);
    flush();
    step();
    check("sat_pred_10", S_PRED, 16'd1);
    check_stats("sat1", 16'd1, 16'd1);
    pred_taken_ID_EX = 1'b1;
    check("sat_fc_correct", S_FC, 16'd0);
    flush();
    step();
    step();
    check_stats("sat3", 16'd3, 16'd1);
    branch(16'h0005, 3'b000, 1'b1);   // NE with z=1: not taken
    check("dec_at", S_AT, 16'd0);
    check("dec_fc", S_FC, 16'd1);
    flush();
    step();
    check("dec_pred_10", S_PRED, 16'd1);
    check_stats("dec1", 16'd4, 16'd2);
    step();
    check("dec_pred_01", S_PRED, 16'd0);
    check_stats("dec2", 16'd5, 16'd3);

    // Mispredict on BEQ with z=0, then jumps
    load_flags(1'b0, 1'b0, 1'b1);
    branch(16'h0002, 3'b001, 1'b1);
    check("beq_fc", S_FC, 16'd1);
    check("beq_at", S_AT, 16'd0);
    flush();
    step();
    check_stats("beq", 16'd6, 16'd4);
    ex_idle();
    jmp_reg_ID_EX = 1'b1;
    check("jr_fc", S_FC, 16'd1);
    check("jr_at", S_AT, 16'd1);
    flush();
    step();
    check_stats("jr", 16'd6, 16'd4);
    branch(16'h0002, 3'b001, 1'b0);
    jmp_imm_ID_EX = 1'b1;
    check("jbr_fc", S_FC, 16'd1);
    check("jbr_at", S_AT, 16'd1);
    flush();
    step();
    check_stats("jbr", 16'd6, 16'd4);

    // Stalled branch trains once, on release
    ex_idle();
    pc_IF = 16'h0007;
    branch(16'h0007, 3'b111, 1'b1);
    stall_ID_EX = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_stats($sformatf("stall_%0d", k), 16'd6, 16'd4);
    end
    stall_ID_EX = 1'b0;
    step();
    check_stats("stall_rel", 16'd7, 16'd4);
    check("stall_pred_10", S_PRED, 16'd1);
    flush();
    branch(16'h0007, 3'b001, 1'b0);   // EQ with z=0: not taken
    step();
    check("stall_pred_01", S_PRED, 16'd0);
    check_stats("stall_nt", 16'd8, 16'd4);

    // Clear dominates a same-cycle training event
    branch(16'h0009, 3'b111, 1'b0);
    clr_stats = 1'b1;
    step();
    check_stats("clr", 16'd0, 16'd0);
    ex_idle();
    step();
    check_stats("clr_idle", 16'd0, 16'd0);
    branch(16'h0009, 3'b111, 1'b1);
    step();
    check_stats("clr_restart", 16'd1, 16'd0);

    // Same-index collision between IF read and EX train
    ex_idle();
    pc_IF = 16'h0003;
    branch(16'h0003, 3'b111, 1'b0);
    check("coll_pre", S_PRED, 16'd0);
    flush();
    step();
    check("coll_post", S_PRED, 16'd1);
    flush();

    // Asynchronous reset mid-sequence
    rst_n = 1'b0;
    check("arst_pred", S_PRED, 16'd0);
    check("arst_zr", S_ZR, 16'd0);
    check_stats("arst", 16'd0, 16'd0);
    step();
    ex_idle();
    rst_n = 1'b1;
    check("post_rst_pred3", S_PRED, 16'd0);
    flush();
    pc_IF = 16'h0009;
    check("post_rst_pred9", S_PRED, 16'd0);
    check_stats("post_rst", 16'd0, 16'd0);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
